parking_sensor_gen: RTL and testbench

- Transmitter side of the parking-lot sensor interface. It drives the two gate-sensor lines (sensor_a, sensor_b) with the exact phase sequences that the occupancy counter decodes.
- Accepts one "car passage" request at a time through a valid/ready handshake and plays it out with programmable phase dwell.
- Used as a synthesizable stimulus source in loopback benches and on board self-test, feeding the counter's sensor inputs directly.

---
 rtl/parkinglot_pkg.sv | 42 ++++
 rtl/parking_sensor_gen_if.sv | 9 +
 rtl/parkgen_dwell_timer.sv | 25 ++
 rtl/parking_sensor_gen.sv | 138 +++++++++++++
 tb/tb_parking_sensor_gen.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/parkinglot_pkg.sv
// Shared encodings for the parking-lot sensor generator: request kinds,
// generator FSM states and the 2-bit (a,b) sensor patterns.
package parkinglot_pkg;

    typedef enum logic [1:0] {
        KIND_ENTER       = 2'b00,
        KIND_EXIT        = 2'b01,
        KIND_ENTER_ABORT = 2'b10,
        KIND_EXIT_ABORT  = 2'b11
    } req_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH1  = 3'd1,
        ST_PH2  = 3'd2,
        ST_PH3  = 3'd3,
        ST_GAP  = 3'd4
    } gen_state_t;

    localparam logic [1:0] SENS_IDLE = 2'b00;
    localparam logic [1:0] SENS_A    = 2'b10;
    localparam logic [1:0] SENS_AB   = 2'b11;
    localparam logic [1:0] SENS_B    = 2'b01;

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Enter-type passages break the outer beam first; PH3 shows which gate the car leaves by.
    function automatic logic [1:0] phase_pattern(input req_kind_t kind, input gen_state_t st);
        logic [1:0] pat;
        pat = SENS_IDLE;
        case (st)
            ST_PH1:  pat = (kind == KIND_ENTER || kind == KIND_ENTER_ABORT) ? SENS_A : SENS_B;
            ST_PH2:  pat = SENS_AB;
            ST_PH3:  pat = (kind == KIND_ENTER || kind == KIND_EXIT_ABORT) ? SENS_B : SENS_A;
            default: pat = SENS_IDLE;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/parking_sensor_gen_if.sv
// Passage-request handshake between a requester and the sensor generator.
interface parking_sensor_gen_if;
    logic       req_valid;
    logic [1:0] req_kind;
    logic       req_ready;

    modport master (output req_valid, output req_kind, input req_ready);
    modport slave  (input req_valid, input req_kind, output req_ready);
endinterface

// File: rtl/parkgen_dwell_timer.sv
// Loadable down-counter with zero flag; times both sensor phases and the gap.
module parkgen_dwell_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/parking_sensor_gen.sv
// Plays one car passage at a time onto sensor_a/sensor_b for the occupancy decoder.
// Optional shadow occupancy counter enabled by `define PARKGEN_SHADOW_COUNT_EN.
module parking_sensor_gen
    import parkinglot_pkg::*;
#(
    parameter int PHASE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1,
    parameter int CAPACITY     = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    parking_sensor_gen_if.slave  req,
    output logic                 sensor_a,
    output logic                 sensor_b,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           expected_count
);

    localparam int TW = $clog2(max2(PHASE_CYCLES, GAP_CYCLES)) + 1;
    localparam logic [TW-1:0] PH_LOAD  = TW'(PHASE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] ONE      = TW'(1);

    gen_state_t     state;
    req_kind_t      kind_q;
    logic           accept;
    logic           tmr_load;
    logic [TW-1:0]  tmr_val;
    logic [TW-1:0]  tmr_cnt;
    logic           tmr_zero;

    assign req.req_ready = (state == ST_IDLE) && reset;
    assign accept        = req.req_valid && req.req_ready;

    // Reload the dwell timer on every state entry that starts a timed interval.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = PH_LOAD;
        case (state)
            ST_IDLE: tmr_load = accept;
            ST_PH1,
            ST_PH2:  tmr_load = tmr_zero;
            ST_PH3: begin
                tmr_load = tmr_zero;
                tmr_val  = GAP_LOAD;
            end
            default: tmr_load = 1'b0;
        endcase
    end

    parkgen_dwell_timer #(.W(TW)) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= ST_IDLE;
            kind_q              <= KIND_ENTER;
            {sensor_a, sensor_b} <= SENS_IDLE;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state               <= ST_PH1;
                        kind_q              <= req_kind_t'(req.req_kind);
                        {sensor_a, sensor_b} <= phase_pattern(req_kind_t'(req.req_kind), ST_PH1);
                        busy                <= 1'b1;
                    end
                end
                ST_PH1: begin
                    if (tmr_zero) begin
                        state               <= ST_PH2;
                        {sensor_a, sensor_b} <= phase_pattern(kind_q, ST_PH2);
                    end
                end
                ST_PH2: begin
                    if (tmr_zero) begin
                        state               <= ST_PH3;
                        {sensor_a, sensor_b} <= phase_pattern(kind_q, ST_PH3);
                    end
                end
                ST_PH3: begin
                    if (tmr_zero) begin
                        state               <= ST_GAP;
                        {sensor_a, sensor_b} <= SENS_IDLE;
                        done                <= (GAP_CYCLES == 1);
                    end
                end
                ST_GAP: begin
                    // done is registered, so it is raised one cycle before the timer hits zero.
                    if (tmr_zero) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else begin
                        done  <= (tmr_cnt == ONE);
                    end
                end
                default: begin
                    state               <= ST_IDLE;
                    {sensor_a, sensor_b} <= SENS_IDLE;
                    busy                <= 1'b0;
                    done                <= 1'b0;
                end
            endcase
        end
    end

`ifdef PARKGEN_SHADOW_COUNT_EN
    localparam logic [2:0] CAP = 3'(CAPACITY);
    logic [2:0] shadow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
        end else if (done) begin
            case (kind_q)
                KIND_ENTER: if (shadow < CAP)  shadow <= shadow + 3'd1;
                KIND_EXIT:  if (shadow != '0) shadow <= shadow - 3'd1;
                default:    shadow <= shadow;
            endcase
        end
    end

    assign expected_count = shadow;
`else
    assign expected_count = 3'd0;
`endif

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Bench for parking_sensor_gen: default instance plus a PHASE=3/GAP=2 instance,
// checked against fixed vectors and a per-passage schedule model.
module tb_parking_sensor_gen;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    parking_sensor_gen_if if0 ();
    parking_sensor_gen_if if1 ();

    logic       a0, b0, busy0, done0;
    logic       a1, b1, busy1, done1;
    logic [2:0] cnt0, cnt1;

    parking_sensor_gen dut0 (
        .clk            (clk),
        .reset          (reset),
        .req            (if0),
        .sensor_a       (a0),
        .sensor_b       (b0),
        .busy           (busy0),
        .done           (done0),
        .expected_count (cnt0)
    );

    parking_sensor_gen #(.PHASE_CYCLES(3), .GAP_CYCLES(2), .CAPACITY(7)) dut1 (
        .clk            (clk),
        .reset          (reset),
        .req            (if1),
        .sensor_a       (a1),
        .sensor_b       (b1),
        .busy           (busy1),
        .done           (done1),
        .expected_count (cnt1)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: each accepted passage becomes a list of per-cycle outputs.
    typedef struct packed {
        logic [1:0] ab;
        logic       busy;
        logic       done;
    } step_t;

    step_t      sched [2][0:15];
    int         slen  [2];
    int         spos  [2];
    int         shadow[2];
    logic [1:0] mkind [2];
    int         pcyc  [2];
    int         gcyc  [2];

    function automatic logic [5:0] kind_seq(input logic [1:0] k);
        case (k)
            2'b00:   return 6'b10_11_01;
            2'b01:   return 6'b01_11_10;
            2'b10:   return 6'b10_11_10;
            default: return 6'b01_11_01;
        endcase
    endfunction

    function automatic logic [2:0] cnt_view(input int c);
`ifdef PARKGEN_SHADOW_COUNT_EN
        return 3'(c);
`else
        return 3'd0;
`endif
    endfunction

    function automatic bit m_ready(input int d);
        return reset && (spos[d] >= slen[d]);
    endfunction

    function automatic logic [7:0] m_obs(input int d);
        step_t s;
        s = '0;
        if (spos[d] < slen[d]) s = sched[d][spos[d]];
        return {s.ab, s.busy, s.done, m_ready(d), cnt_view(shadow[d])};
    endfunction

    function automatic logic [7:0] dut_obs(input int d);
        if (d == 0) return {a0, b0, busy0, done0, if0.req_ready, cnt0};
        return {a1, b1, busy1, done1, if1.req_ready, cnt1};
    endfunction

    task automatic m_edge(input int d, input bit acc, input logic [1:0] k);
        logic [5:0] p;
        int n;
        if (spos[d] < slen[d]) begin
            if (sched[d][spos[d]].done) begin
                if (mkind[d] == 2'b00 && shadow[d] < 7) shadow[d]++;
                else if (mkind[d] == 2'b01 && shadow[d] > 0) shadow[d]--;
            end
            spos[d]++;
        end
        if (acc) begin
            p = kind_seq(k);
            n = 0;
            mkind[d] = k;
            for (int ph = 0; ph < 3; ph++)
                for (int i = 0; i < pcyc[d]; i++) begin
                    sched[d][n] = '{ab: p[5-2*ph -: 2], busy: 1'b1, done: 1'b0};
                    n++;
                end
            for (int i = 0; i < gcyc[d]; i++) begin
                sched[d][n] = '{ab: 2'b00, busy: 1'b1, done: (i == gcyc[d] - 1)};
                n++;
            end
            slen[d] = n;
            spos[d] = 0;
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            slen[d] = 0; spos[d] = 0; shadow[d] = 0;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got ab/busy/done/rdy/cnt=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
                     name, act[7:6], act[5], act[4], act[3], act[2:0],
                     exp[7:6], exp[5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    // Called at a falling edge: drive, clock once, then compare both DUTs with the model.
    task automatic cycle(input bit v0, input logic [1:0] k0, input bit v1, input logic [1:0] k1,
                         input string tag);
        bit acc0, acc1;
        if0.req_valid = v0; if0.req_kind = k0;
        if1.req_valid = v1; if1.req_kind = k1;
        acc0 = v0 && m_ready(0);
        acc1 = v1 && m_ready(1);
        @(posedge clk);
        m_edge(0, acc0, k0);
        m_edge(1, acc1, k1);
        @(negedge clk);
        check({tag, "/d0"}, dut_obs(0), m_obs(0));
        check({tag, "/d1"}, dut_obs(1), m_obs(1));
    endtask

    typedef struct {
        bit         v;
        logic [1:0] k;
        logic [1:0] ab;
        bit         busy;
        bit         done;
        bit         rdy;
        int         cnt;
    } vec_t;

    vec_t tbl [15];

    function automatic logic [7:0] p3g2_expect(input int c);
        logic [1:0] ab;
        ab = (c <= 3) ? 2'b10 : (c <= 6) ? 2'b11 : (c <= 9) ? 2'b01 : 2'b00;
        return {ab, 1'(c <= 11), 1'(c == 11), 1'(c == 12), cnt_view((c == 12) ? 1 : 0)};
    endfunction

    initial begin
        pcyc[0] = 1; gcyc[0] = 1;
        pcyc[1] = 3; gcyc[1] = 2;
        mkind[0] = 2'b00; mkind[1] = 2'b00;
        m_reset();
        if0.req_valid = 1'b0; if0.req_kind = 2'b00;
        if1.req_valid = 1'b0; if1.req_kind = 2'b00;

        //              v  kind   ab    busy done rdy cnt
        tbl[0]  = '{1, 2'b00, 2'b10, 1, 0, 0, 0};
        tbl[1]  = '{0, 2'b00, 2'b11, 1, 0, 0, 0};
        tbl[2]  = '{0, 2'b00, 2'b01, 1, 0, 0, 0};
        tbl[3]  = '{0, 2'b00, 2'b00, 1, 1, 0, 0};
        tbl[4]  = '{0, 2'b00, 2'b00, 0, 0, 1, 1};
        tbl[5]  = '{1, 2'b01, 2'b01, 1, 0, 0, 1};
        tbl[6]  = '{1, 2'b11, 2'b11, 1, 0, 0, 1};
        tbl[7]  = '{1, 2'b11, 2'b10, 1, 0, 0, 1};
        tbl[8]  = '{1, 2'b11, 2'b00, 1, 1, 0, 1};
        tbl[9]  = '{1, 2'b11, 2'b00, 0, 0, 1, 0};
        tbl[10] = '{1, 2'b11, 2'b01, 1, 0, 0, 0};
        tbl[11] = '{1, 2'b11, 2'b11, 1, 0, 0, 0};
        tbl[12] = '{1, 2'b11, 2'b01, 1, 0, 0, 0};
        tbl[13] = '{1, 2'b11, 2'b00, 1, 1, 0, 0};
        tbl[14] = '{0, 2'b00, 2'b00, 0, 0, 1, 0};

        repeat (3) @(negedge clk);
        check("reset/d0", dut_obs(0), 8'b0);
        check("reset/d1", dut_obs(1), 8'b0);
        reset = 1'b1;
        #1;
        check("release/d0", dut_obs(0), {5'b00001, 3'd0});
        check("release/d1", dut_obs(1), {5'b00001, 3'd0});

        // Enter, then exit and exit-abort back-to-back with valid held high.
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].v, tbl[i].k, 1'b0, 2'b00, $sformatf("tbl%0d", i));
            check($sformatf("tblrow%0d", i), dut_obs(0),
                  {tbl[i].ab, tbl[i].busy, tbl[i].done, tbl[i].rdy, cnt_view(tbl[i].cnt)});
        end

        // Eight enters: occupancy saturates at capacity.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 2'b00, 1'b0, 2'b00, "enter8");
            repeat (4) cycle(1'b0, 2'b00, 1'b0, 2'b00, "enter8");
            check($sformatf("sat%0d", i), dut_obs(0),
                  {5'b00001, cnt_view((i + 1 > 7) ? 7 : i + 1)});
        end

        // Long-dwell instance, single enter.
        for (int c = 1; c <= 12; c++) begin
            cycle(1'b0, 2'b00, c == 1, 2'b00, "p3g2");
            check($sformatf("p3g2_c%0d", c), dut_obs(1), p3g2_expect(c));
        end

        // A request pulsed during PH1 must be dropped.
        cycle(1'b1, 2'b00, 1'b0, 2'b00, "ign");
        cycle(1'b1, 2'b01, 1'b0, 2'b00, "ign");
        repeat (5) cycle(1'b0, 2'b00, 1'b0, 2'b00, "ign");

        // Asynchronous reset in PH2 of an enter.
        cycle(1'b1, 2'b00, 1'b1, 2'b00, "rst_pre");
        cycle(1'b0, 2'b00, 1'b0, 2'b00, "rst_pre");
        reset = 1'b0;
        #1;
        m_reset();
        check("async_rst/d0", dut_obs(0), 8'b0);
        check("async_rst/d1", dut_obs(1), 8'b0);
        repeat (2) @(negedge clk);
        check("rst_hold/d0", dut_obs(0), 8'b0);
        check("rst_hold/d1", dut_obs(1), 8'b0);
        reset = 1'b1;
        #1;
        check("rst_rel/d0", dut_obs(0), m_obs(0));
        check("rst_rel/d1", dut_obs(1), m_obs(1));
        cycle(1'b1, 2'b00, 1'b1, 2'b00, "post_rst");
        repeat (14) cycle(1'b0, 2'b00, 1'b0, 2'b00, "post_rst");

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
